// File: rtl/alu_serial_logic_unit_pkg.sv
// Package alu_pkg: shared definitions for the serial ALU logic unit.
//   - Op-code encodings used on req_op and by the slice datapath.
//   - FSM state encoding of the serial unit (IDLE -> BUSY -> DONE).
package alu_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_serial_logic_unit_if.sv
// Interface alu_serial_logic_unit_if: request/response bundle of the serial ALU logic unit.
//   Request : req_valid, req_ready, req_op[1:0], req_a[WIDTH], req_b[WIDTH]
//   Response: resp_valid, resp_ready, resp_data[WIDTH], resp_zero
//   Status  : busy
//   master = issuer/consumer side, slave = the unit.
interface alu_serial_logic_unit_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_zero;
   logic             busy;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_zero, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_zero, busy
   );
endinterface

// File: rtl/alu_serial_logic_unit_slice.sv
// Module alu_logic_slice: combinational SLICE-bit bitwise operation.
//   op [1:0]     : operation select (AND/OR/XOR/XNOR)
//   a, b [SLICE] : operand slices
//   y [SLICE]    : result slice
module alu_logic_slice
   import alu_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [1:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] y
);

   // Bitwise operation select
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_serial_logic_unit.sv
// Module alu_serial_logic_unit: multi-cycle AND/OR/XOR/XNOR responder.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : slave side of alu_serial_logic_unit_if (request, response, busy)
// Operands are captured on accept, then SLICE bits are computed per cycle,
// LSB slice first. The finished result and its zero flag are published into
// dedicated output registers on the last slice and held until the next completion.
module alu_serial_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input logic                    clk,
   input logic                    rst,
   alu_serial_logic_unit_if.slave bus
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("alu_serial_logic_unit: WIDTH must be a multiple of SLICE");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic             resp_zero_q, resp_zero_d;
   logic             req_ready_q, req_ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic             busy_q, busy_d;

   logic [SLICE-1:0] a_slice;
   logic [SLICE-1:0] b_slice;
   logic [SLICE-1:0] y_slice;

   assign a_slice = a_q[cnt_q*SLICE +: SLICE];
   assign b_slice = b_q[cnt_q*SLICE +: SLICE];

   alu_logic_slice #(.SLICE(SLICE)) u_slice (
      .op (op_q),
      .a  (a_slice),
      .b  (b_slice),
      .y  (y_slice)
   );

   // Next-state, datapath and output-flag computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      result_d    = result_q;
      resp_data_d = resp_data_q;
      resp_zero_d = resp_zero_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               op_d    = bus.req_op;
               cnt_d   = '0;
               state_d = S_BUSY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            result_d[cnt_q*SLICE +: SLICE] = y_slice;
            if (cnt_q == LAST_CNT) begin
               // Publish the complete word including the slice written this cycle
               resp_data_d = result_d;
               resp_zero_d = ~|result_d;
               cnt_d       = '0;
               state_d     = S_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_BUSY;
            end
         end
         S_DONE: begin
            if (bus.resp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Handshake flags are registered copies of the next state decode
      req_ready_d  = (state_d == S_IDLE);
      resp_valid_d = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
   end

   // State, operand, result and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 2'b00;
         result_q     <= '0;
         resp_data_q  <= '0;
         resp_zero_q  <= 1'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         result_q     <= result_d;
         resp_data_q  <= resp_data_d;
         resp_zero_q  <= resp_zero_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_zero  = resp_zero_q;
   assign bus.busy       = busy_q;

endmodule
